// File: rtl/map_ss_seq_pkg.sv
// map_ss_seq_pkg
// Shared definitions for the mapper save-state sequencer: the FSM state
// encoding, default slot count and index slot, and a helper used to step
// the load slot counter past the read-only mapper index slot.
package map_ss_seq_pkg;

  // Sequencer states. IDLE must stay at zero so a cleared register is idle.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_SET = 3'd1,
    S_WR  = 3'd2,
    L_CHK = 3'd3,
    L_RD  = 3'd4,
    L_SET = 3'd5,
    L_WR  = 3'd6,
    FIN   = 3'd7
  } state_t;

  localparam int SS_LEN_DEF = 128;
  localparam int SS_IDX_DEF = 127;

  // Slot counter is one bit wider than the 8-bit slot address so that a
  // 256-slot save can reach its final slot without wrapping to zero.
  localparam int SLOT_W = 9;

  // Returns s, or s+1 when s lands on the index slot. Computed at 10 bits
  // so that the step past slot 255 is still representable.
  function automatic logic [9:0] skip_idx(input logic [9:0] s,
                                          input logic [9:0] idx);
    return (s == idx) ? s + 10'd1 : s;
  endfunction

endpackage

// File: rtl/map_ss_seq_mem_port.sv
// ss_mem_port
// Owns the backing-memory request/acknowledge handshake for the sequencer.
//
// Handshake: a one-cycle go pulse captures req_we/req_addr/req_wdat and
// raises mem_req on the next edge. mem_req, mem_we, mem_addr and mem_wdat
// then hold steady until mem_ack is seen high while mem_req is high; that
// cycle is the transfer, fin is high for exactly that cycle, and mem_req
// drops on the following edge. mem_ack while mem_req is low is ignored.
// go must only be pulsed while no request is outstanding.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   go                        one-cycle request launch
//   req_we, req_addr, req_wdat  request attributes captured on go
//   mem_req, mem_we, mem_addr, mem_wdat  memory request outputs (registered)
//   mem_ack                   one-cycle acknowledge from memory
//   fin                       high in the accepted acknowledge cycle
module ss_mem_port (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdat,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdat,
  input  logic        mem_ack,
  output logic        fin
);

  assign fin = mem_req & mem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= 16'd0;
      mem_wdat <= 8'd0;
    end else if (go) begin
      mem_req  <= 1'b1;
      mem_we   <= req_we;
      mem_addr <= req_addr;
      mem_wdat <= req_wdat;
    end else if (fin) begin
      mem_req  <= 1'b0;
    end
  end

  a_no_go_while_busy: assert property (@(posedge clk) disable iff (rst)
    go |-> !mem_req);

endmodule

// File: rtl/map_ss_seq.sv
// map_ss_seq
// Mapper save-state sequencer. A save walks every mapper slot, reading the
// mapper register and writing it to backing memory at MEM_BASE + slot. A
// load first compares the stored mapper index (slot SS_IDX_ADDR) against
// the live mapper index; on a match it reads every other slot back from
// memory and writes it into the mapper, on a mismatch it raises err and
// stops without touching the mapper.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start_save, start_load one-cycle start pulses (save wins if both)
//   ss_act                 mapper save-state access active
//   ss_we, ss_addr, ss_wdat  mapper write strobe, slot index, write data
//   ss_rdat                mapper readback of ss_addr (combinational)
//   mem_req, mem_we, mem_addr, mem_wdat, mem_rdat, mem_ack  backing memory
//   busy                   sequence in progress
//   done                   one-cycle pulse on successful completion
//   err                    sticky index mismatch, cleared by the next start
module map_ss_seq
  import map_ss_seq_pkg::*;
#(
  parameter int          SS_LEN      = SS_LEN_DEF,
  parameter int          SS_IDX_ADDR = SS_IDX_DEF,
  parameter logic [15:0] MEM_BASE    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_save,
  input  logic        start_load,
  output logic        ss_act,
  output logic        ss_we,
  output logic [7:0]  ss_addr,
  output logic [7:0]  ss_wdat,
  input  logic [7:0]  ss_rdat,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdat,
  input  logic [7:0]  mem_rdat,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [SLOT_W-1:0] LAST  = SLOT_W'(SS_LEN - 1);
  localparam logic [SLOT_W-1:0] IDX9  = SLOT_W'(SS_IDX_ADDR);
  localparam logic [9:0]        IDX10 = 10'(SS_IDX_ADDR);
  localparam logic [9:0]        LEN10 = 10'(SS_LEN);

  // FSM state is kept as a typed signal so checkers can bind to it.
  state_t              state;
  logic [SLOT_W-1:0]   slot;
  logic                armed;   // set on the first edge after reset
  logic                go;      // one-cycle request launch to the port
  logic [7:0]          wdat_q;  // mapper readback captured in S_SET
  logic                fin;
  logic                req_we;
  logic [SLOT_W-1:0]   req_slot;
  logic [15:0]         req_addr;
  logic [9:0]          ld_first;
  logic [9:0]          ld_next;

  assign busy   = (state != IDLE);
  assign ss_act = busy;

  // The index check reads slot SS_IDX_ADDR; every other request uses the
  // slot counter. Address arithmetic wraps modulo 2^16.
  assign req_slot = (state == L_CHK) ? IDX9 : slot;
  assign req_addr = MEM_BASE + {7'd0, req_slot};
  assign req_we   = (state == S_WR);

  // Load never visits the index slot, so both the first slot and each
  // successor are stepped over it.
  assign ld_first = skip_idx(10'd0, IDX10);
  assign ld_next  = skip_idx({1'b0, slot} + 10'd1, IDX10);

  ss_mem_port u_port (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdat (wdat_q),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdat (mem_wdat),
    .mem_ack  (mem_ack),
    .fin      (fin)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      slot    <= '0;
      armed   <= 1'b0;
      go      <= 1'b0;
      wdat_q  <= 8'd0;
      ss_we   <= 1'b0;
      ss_addr <= 8'd0;
      ss_wdat <= 8'd0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      armed <= 1'b1;
      go    <= 1'b0;
      done  <= 1'b0;
      ss_we <= 1'b0;
      case (state)
        IDLE: begin
          if (armed && start_save) begin
            err     <= 1'b0;
            slot    <= '0;
            ss_addr <= 8'd0;
            state   <= S_SET;
          end else if (armed && start_load) begin
            err     <= 1'b0;
            slot    <= '0;
            ss_addr <= IDX9[7:0];
            go      <= 1'b1;
            state   <= L_CHK;
          end
        end
        // ss_addr has been stable for this cycle; capture the readback.
        S_SET: begin
          wdat_q <= ss_rdat;
          go     <= 1'b1;
          state  <= S_WR;
        end
        S_WR: begin
          if (fin) begin
            if (slot == LAST) begin
              state <= FIN;
            end else begin
              slot    <= slot + 1'b1;
              ss_addr <= slot[7:0] + 8'd1;
              state   <= S_SET;
            end
          end
        end
        // ss_addr still points at the index slot, so ss_rdat is the live
        // mapper index to compare against the stored one.
        L_CHK: begin
          if (fin) begin
            if (mem_rdat != ss_rdat) begin
              err   <= 1'b1;
              state <= IDLE;
            end else begin
              slot  <= ld_first[SLOT_W-1:0];
              go    <= 1'b1;
              state <= L_RD;
            end
          end
        end
        L_RD: begin
          if (fin) begin
            ss_wdat <= mem_rdat;
            ss_addr <= slot[7:0];
            state   <= L_SET;
          end
        end
        L_SET: begin
          ss_we <= 1'b1;
          state <= L_WR;
        end
        L_WR: begin
          if (ld_next >= LEN10) begin
            state <= FIN;
          end else begin
            slot  <= ld_next[SLOT_W-1:0];
            go    <= 1'b1;
            state <= L_RD;
          end
        end
        // done rises as the FSM re-enters IDLE, so it never overlaps ss_act.
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_req_idle_fin: assert property (@(posedge clk) disable iff (rst)
    (state == IDLE || state == FIN) |-> !mem_req);
  a_we_only_in_lwr: assert property (@(posedge clk) disable iff (rst)
    ss_we |-> (state == L_WR));
  a_done_not_act: assert property (@(posedge clk) disable iff (rst)
    done |-> !ss_act);

endmodule

// File: tb/tb_map_ss_seq.sv
// tb_map_ss_seq
// Bench for map_ss_seq. dut_a uses the default geometry (128 slots, index
// slot 127, base 0); dut_b uses 256 slots, index slot 255 and a base of
// 16'hFF80 so the address wraps modulo 2^16. A single model process acts
// as the stub mapper log and the backing memory (ack on the 3rd cycle
// after a request) for both instances.
module tb_map_ss_seq;

  logic clk;
  logic rst;

  logic [1:0]       start_save, start_load;
  logic [1:0]       ss_act, ss_we, mem_req, mem_we, mem_ack, busy, done, err;
  logic [1:0][7:0]  ss_addr, ss_wdat, ss_rdat, mem_wdat, mem_rdat;
  logic [1:0][15:0] mem_addr;

  // Stimulus-side storage (written only by the initial block).
  logic [7:0] map_rd [2][256];
  logic [7:0] rd_mem [2][256];

  // Model-side logs (written only by the model process).
  logic [7:0]  wr_log   [2][256];
  int          wr_hits  [2][256];
  logic [7:0]  map_wr   [2][256];
  int          map_hits [2][256];
  int          wr_cnt [2], rd_cnt [2], we_cnt [2], done_cnt [2];
  logic [15:0] first_addr [2], last_addr [2];
  logic [1:0]  ack_cnt [2];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [15:0] base_of(input int g);
    return (g == 0) ? 16'h0000 : 16'hFF80;
  endfunction

  map_ss_seq dut_a (
    .clk(clk), .rst(rst), .start_save(start_save[0]), .start_load(start_load[0]),
    .ss_act(ss_act[0]), .ss_we(ss_we[0]), .ss_addr(ss_addr[0]), .ss_wdat(ss_wdat[0]),
    .ss_rdat(ss_rdat[0]), .mem_req(mem_req[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_wdat(mem_wdat[0]), .mem_rdat(mem_rdat[0]),
    .mem_ack(mem_ack[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  map_ss_seq #(.SS_LEN(256), .SS_IDX_ADDR(255), .MEM_BASE(16'hFF80)) dut_b (
    .clk(clk), .rst(rst), .start_save(start_save[1]), .start_load(start_load[1]),
    .ss_act(ss_act[1]), .ss_we(ss_we[1]), .ss_addr(ss_addr[1]), .ss_wdat(ss_wdat[1]),
    .ss_rdat(ss_rdat[1]), .mem_req(mem_req[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_wdat(mem_wdat[1]), .mem_rdat(mem_rdat[1]),
    .mem_ack(mem_ack[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- models ----------------
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      ss_rdat[g]  = map_rd[g][ss_addr[g]];
      mem_rdat[g] = rd_mem[g][8'(mem_addr[g] - base_of(g))];
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < 2; g++) begin
        mem_ack[g]    <= 1'b0;
        ack_cnt[g]    <= 2'd0;
        wr_cnt[g]     <= 0;
        rd_cnt[g]     <= 0;
        we_cnt[g]     <= 0;
        done_cnt[g]   <= 0;
        first_addr[g] <= 16'd0;
        last_addr[g]  <= 16'd0;
        for (int i = 0; i < 256; i++) begin
          wr_log[g][i]   <= 8'd0;
          wr_hits[g][i]  <= 0;
          map_wr[g][i]   <= 8'd0;
          map_hits[g][i] <= 0;
        end
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (mem_ack[g]) begin
          mem_ack[g] <= 1'b0;
          ack_cnt[g] <= 2'd0;
          if (mem_we[g]) begin
            wr_log[g][8'(mem_addr[g] - base_of(g))]  <= mem_wdat[g];
            wr_hits[g][8'(mem_addr[g] - base_of(g))] <= wr_hits[g][8'(mem_addr[g] - base_of(g))] + 1;
            if (wr_cnt[g] == 0) first_addr[g] <= mem_addr[g];
            last_addr[g] <= mem_addr[g];
            wr_cnt[g]    <= wr_cnt[g] + 1;
          end else begin
            rd_cnt[g] <= rd_cnt[g] + 1;
          end
        end else if (mem_req[g]) begin
          if (ack_cnt[g] == 2'd2) mem_ack[g] <= 1'b1;
          else ack_cnt[g] <= ack_cnt[g] + 2'd1;
        end
        if (ss_we[g]) begin
          map_wr[g][ss_addr[g]]   <= ss_wdat[g];
          map_hits[g][ss_addr[g]] <= map_hits[g][ss_addr[g]] + 1;
          we_cnt[g] <= we_cnt[g] + 1;
        end
        if (done[g]) done_cnt[g] <= done_cnt[g] + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic init_mapper(input int g);
    for (int i = 0; i < 256; i++) map_rd[g][i] = 8'(i) ^ 8'h5A;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start_save = 2'b00;
    start_load = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_save(input int g);
    start_save[g] = 1'b1;
    @(negedge clk);
    start_save[g] = 1'b0;
  endtask

  task automatic pulse_load(input int g);
    start_load[g] = 1'b1;
    @(negedge clk);
    start_load[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget);
    int n = 0;
    while (done_cnt[g] == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (done_cnt[g] == 0) begin
      n_bad++;
      $display("FAIL wait_done[%0d]: no done after %0d cycles, expected done", g, budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [46:0] outs;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    outs = {ss_act[0], ss_we[0], ss_addr[0], ss_wdat[0], mem_req[0], mem_we[0],
            mem_addr[0], mem_wdat[0], busy[0], done[0], err[0]};
    n_cmp++;
    if (outs !== 47'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    n_cmp++;
    if (mem_addr[1] !== 16'd0 || busy[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_b: got addr %h busy %b expected 0 0", mem_addr[1], busy[1]);
    end
    // Start presented for the first edge after release must be ignored.
    rst = 1'b0;
    start_save[0] = 1'b1;
    @(negedge clk);
    start_save[0] = 1'b0;
    n_cmp++;
    if (busy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL start_first_edge: busy got %b expected 0", busy[0]);
    end
    start_save[0] = 1'b1;
    @(negedge clk);
    start_save[0] = 1'b0;
    n_cmp++;
    if (busy[0] !== 1'b1 || ss_act[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL start_second_edge: busy %b ss_act %b expected 1 1", busy[0], ss_act[0]);
    end
  endtask

  task automatic test_save();
    int bad = 0;
    init_mapper(0);
    do_reset();
    pulse_save(0);
    wait_done(0, 3000);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (wr_cnt[0] !== 128) begin
      n_bad++;
      $display("FAIL save_count: got %0d expected 128", wr_cnt[0]);
    end
    for (int i = 0; i < 128; i++)
      if (wr_hits[0][i] != 1 || wr_log[0][i] !== (8'(i) ^ 8'h5A)) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL save_data: %0d bad slots expected 0", bad);
    end
    n_cmp++;
    if (wr_log[0][1] !== 8'h5B || wr_log[0][127] !== 8'h25) begin
      n_bad++;
      $display("FAIL save_spot: got %h %h expected 5b 25", wr_log[0][1], wr_log[0][127]);
    end
    n_cmp++;
    if (first_addr[0] !== 16'h0000 || last_addr[0] !== 16'h007F) begin
      n_bad++;
      $display("FAIL save_addr: got %h..%h expected 0000..007f", first_addr[0], last_addr[0]);
    end
    n_cmp++;
    if (done_cnt[0] !== 1 || err[0] !== 1'b0 || we_cnt[0] !== 0 || busy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL save_end: done %0d err %b we %0d busy %b expected 1 0 0 0",
               done_cnt[0], err[0], we_cnt[0], busy[0]);
    end
  endtask

  task automatic test_load();
    int bad = 0;
    init_mapper(0);
    for (int i = 0; i < 256; i++) rd_mem[0][i] = 8'(i) ^ 8'hC3;
    rd_mem[0][0]   = 8'hF3;
    rd_mem[0][127] = 8'h0B;
    map_rd[0][127] = 8'h0B;
    do_reset();
    pulse_load(0);
    wait_done(0, 3000);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (we_cnt[0] !== 127) begin
      n_bad++;
      $display("FAIL load_we_count: got %0d expected 127", we_cnt[0]);
    end
    n_cmp++;
    if (map_wr[0][0] !== 8'hF3) begin
      n_bad++;
      $display("FAIL load_slot0: got %h expected f3", map_wr[0][0]);
    end
    n_cmp++;
    if (map_hits[0][127] !== 0) begin
      n_bad++;
      $display("FAIL load_skip_idx: got %0d writes expected 0", map_hits[0][127]);
    end
    n_cmp++;
    if (map_wr[0][1] !== 8'hC2 || map_wr[0][126] !== 8'hBD) begin
      n_bad++;
      $display("FAIL load_spot: got %h %h expected c2 bd", map_wr[0][1], map_wr[0][126]);
    end
    for (int i = 1; i < 127; i++)
      if (map_hits[0][i] != 1 || map_wr[0][i] !== (8'(i) ^ 8'hC3)) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL load_data: %0d bad slots expected 0", bad);
    end
    n_cmp++;
    if (rd_cnt[0] !== 128 || wr_cnt[0] !== 0 || done_cnt[0] !== 1 || err[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL load_end: rd %0d wr %0d done %0d err %b expected 128 0 1 0",
               rd_cnt[0], wr_cnt[0], done_cnt[0], err[0]);
    end
  endtask

  task automatic test_mismatch();
    int n = 0;
    init_mapper(0);
    rd_mem[0][127] = 8'h0B;
    map_rd[0][127] = 8'h90;
    do_reset();
    pulse_load(0);
    while (mem_ack[0] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (mem_ack[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL mismatch_ack: no ack within 50 cycles expected ack");
    end
    @(negedge clk);
    n_cmp++;
    if (busy[0] !== 1'b0 || err[0] !== 1'b1 || mem_req[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL mismatch_stop: busy %b err %b req %b expected 0 1 0",
               busy[0], err[0], mem_req[0]);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (we_cnt[0] !== 0 || done_cnt[0] !== 0 || err[0] !== 1'b1 || rd_cnt[0] !== 1) begin
      n_bad++;
      $display("FAIL mismatch_quiet: we %0d done %0d err %b rd %0d expected 0 0 1 1",
               we_cnt[0], done_cnt[0], err[0], rd_cnt[0]);
    end
    // The next accepted start clears the sticky flag.
    init_mapper(0);
    pulse_save(0);
    n_cmp++;
    if (err[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clear: got %b expected 0", err[0]);
    end
    wait_done(0, 3000);
  endtask

  task automatic test_collision();
    init_mapper(0);
    do_reset();
    start_save[0] = 1'b1;
    start_load[0] = 1'b1;
    @(negedge clk);
    start_save[0] = 1'b0;
    start_load[0] = 1'b0;
    repeat (3) @(negedge clk);
    pulse_load(0);
    wait_done(0, 3000);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (wr_cnt[0] !== 128 || rd_cnt[0] !== 0 || we_cnt[0] !== 0) begin
      n_bad++;
      $display("FAIL collision_save_only: wr %0d rd %0d we %0d expected 128 0 0",
               wr_cnt[0], rd_cnt[0], we_cnt[0]);
    end
    n_cmp++;
    if (done_cnt[0] !== 1 || busy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL collision_end: done %0d busy %b expected 1 0", done_cnt[0], busy[0]);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int bad = 0;
    init_mapper(0);
    do_reset();
    pulse_save(0);
    while (!(mem_req[0] === 1'b1 && mem_addr[0] === 16'd40 && mem_ack[0] === 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (mem_addr[0] !== 16'd40 || mem_req[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_reach: addr %h req %b expected 0028 1", mem_addr[0], mem_req[0]);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ss_act[0] !== 1'b0 || mem_req[0] !== 1'b0 || busy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_async: ss_act %b req %b busy %b expected 0 0 0",
               ss_act[0], mem_req[0], busy[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_save(0);
    wait_done(0, 3000);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 128; i++)
      if (wr_hits[0][i] != 1 || wr_log[0][i] !== (8'(i) ^ 8'h5A)) bad++;
    n_cmp++;
    if (wr_cnt[0] !== 128 || first_addr[0] !== 16'h0000 || bad != 0 || done_cnt[0] !== 1) begin
      n_bad++;
      $display("FAIL reset_mid_rerun: wr %0d first %h bad %0d done %0d expected 128 0000 0 1",
               wr_cnt[0], first_addr[0], bad, done_cnt[0]);
    end
  endtask

  task automatic test_boundary();
    int bad = 0;
    init_mapper(1);
    do_reset();
    pulse_save(1);
    wait_done(1, 5000);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (wr_cnt[1] !== 256) begin
      n_bad++;
      $display("FAIL bound_count: got %0d expected 256", wr_cnt[1]);
    end
    for (int i = 0; i < 256; i++)
      if (wr_hits[1][i] != 1 || wr_log[1][i] !== (8'(i) ^ 8'h5A)) bad++;
    n_cmp++;
    if (bad != 0 || wr_log[1][255] !== 8'hA5) begin
      n_bad++;
      $display("FAIL bound_data: %0d bad slots, slot255 %h expected 0 a5", bad, wr_log[1][255]);
    end
    n_cmp++;
    if (first_addr[1] !== 16'hFF80 || last_addr[1] !== 16'h007F) begin
      n_bad++;
      $display("FAIL bound_addr: got %h..%h expected ff80..007f", first_addr[1], last_addr[1]);
    end
    n_cmp++;
    if (done_cnt[1] !== 1 || busy[1] !== 1'b0 || err[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL bound_end: done %0d busy %b err %b expected 1 0 0",
               done_cnt[1], busy[1], err[1]);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    start_save = 2'b00;
    start_load = 2'b00;
    init_mapper(0);
    init_mapper(1);
    for (int i = 0; i < 256; i++) begin
      rd_mem[0][i] = 8'd0;
      rd_mem[1][i] = 8'd0;
    end
    test_reset();
    test_save();
    test_load();
    test_mismatch();
    test_collision();
    test_reset_mid();
    test_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
